// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank: multi-ported register file (one write port, two read ports).
//
// Parameters:
//   DATA_WIDTH : width of each register and of the data ports
//   ADDR_WIDTH : register index width; NREGS = 2**ADDR_WIDTH registers
//   ZERO_REG   : 1 -> register 0 is hardwired to zero
//   BYPASS     : 1 -> same-cycle write data is forwarded to the read ports
//
// Ports:
//   CLK      in  : clock, state updates on the rising edge
//   RST_N    in  : asynchronous active-low reset, clears every register
//   WE       in  : write enable
//   WADDR    in  : write register index
//   WDATA    in  : write data
//   RADDR_A  in  : read port A register index
//   RDATA_A  out : read port A data (combinational)
//   RADDR_B  in  : read port B register index
//   RDATA_B  out : read port B data (combinational)
//   WEN_VEC  out : one-hot decoded write-enable vector
// ---------------------------------------------------------------------------
module reg_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1,
    localparam int unsigned NREGS     = 2 ** ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [ADDR_WIDTH-1:0] RADDR_A,
    output logic [DATA_WIDTH-1:0] RDATA_A,
    input  logic [ADDR_WIDTH-1:0] RADDR_B,
    output logic [DATA_WIDTH-1:0] RDATA_B,
    output logic [NREGS-1:0]      WEN_VEC
);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0]      wen_vec;

    // Write decode; the hardwired zero register never receives an enable.
    always_comb begin
        wen_vec = '0;
        if (WE) begin
            wen_vec[WADDR] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            wen_vec[0] = 1'b0;
        end
    end

    assign WEN_VEC = wen_vec;

    always_comb begin
        for (int unsigned k = 0; k < NREGS; k++) begin
            regs_d[k] = wen_vec[k] ? WDATA : regs_q[k];
        end
    end

    // Asynchronous clear; any write presented while reset is low is dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Read ports. Priority: hardwired zero, then forwarding, then storage.
    // Forwarding is independent of reset, so a write presented during reset
    // is still visible on a matching read port while storage reads as zero.
    logic zero_a, zero_b;
    logic fwd_a, fwd_b;

    always_comb begin
        zero_a  = (ZERO_REG != 0) && (RADDR_A == '0);
        zero_b  = (ZERO_REG != 0) && (RADDR_B == '0);
        fwd_a   = (BYPASS != 0) && WE && (WADDR == RADDR_A);
        fwd_b   = (BYPASS != 0) && WE && (WADDR == RADDR_B);

        RDATA_A = regs_q[RADDR_A];
        if (zero_a) begin
            RDATA_A = '0;
        end else if (fwd_a) begin
            RDATA_A = WDATA;
        end

        RDATA_B = regs_q[RADDR_B];
        if (zero_b) begin
            RDATA_B = '0;
        end else if (fwd_b) begin
            RDATA_B = WDATA;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_bank: scoreboard bench for reg_bank.
// Four instances share one clock and reset:
//   m   : defaults (32/5, ZERO_REG=1, BYPASS=1)
//   nb  : BYPASS=0, shares the write/read inputs of m
//   z0  : ZERO_REG=0, shares the write/read inputs of m
//   s   : ADDR_WIDTH=3, DATA_WIDTH=8, own inputs
// ---------------------------------------------------------------------------
module tb_reg_bank;

    logic        CLK;
    logic        RST_N;
    logic        WE;
    logic [4:0]  WADDR;
    logic [31:0] WDATA;
    logic [4:0]  RADDR_A;
    logic [4:0]  RADDR_B;

    logic [31:0] m_rdata_a, m_rdata_b, nb_rdata_a, nb_rdata_b, z0_rdata_a, z0_rdata_b;
    logic [31:0] m_wen, nb_wen, z0_wen;

    logic        s_we;
    logic [2:0]  s_waddr, s_raddr_a, s_raddr_b;
    logic [7:0]  s_wdata, s_rdata_a, s_rdata_b;
    logic [7:0]  s_wen;

    reg_bank u_m (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RADDR_A(RADDR_A), .RDATA_A(m_rdata_a), .RADDR_B(RADDR_B),
        .RDATA_B(m_rdata_b), .WEN_VEC(m_wen)
    );

    reg_bank #(.BYPASS(0)) u_nb (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RADDR_A(RADDR_A), .RDATA_A(nb_rdata_a), .RADDR_B(RADDR_B),
        .RDATA_B(nb_rdata_b), .WEN_VEC(nb_wen)
    );

    reg_bank #(.ZERO_REG(0)) u_z0 (
        .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RADDR_A(RADDR_A), .RDATA_A(z0_rdata_a), .RADDR_B(RADDR_B),
        .RDATA_B(z0_rdata_b), .WEN_VEC(z0_wen)
    );

    reg_bank #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) u_s (
        .CLK(CLK), .RST_N(RST_N), .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata),
        .RADDR_A(s_raddr_a), .RDATA_A(s_rdata_a), .RADDR_B(s_raddr_b),
        .RDATA_B(s_rdata_b), .WEN_VEC(s_wen)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Signal selectors for scoreboard entries
    localparam int SIG_M_A   = 0;
    localparam int SIG_M_B   = 1;
    localparam int SIG_M_WEN = 2;
    localparam int SIG_NB_A  = 3;
    localparam int SIG_NB_B  = 4;
    localparam int SIG_Z0_A  = 5;
    localparam int SIG_Z0_WEN = 6;
    localparam int SIG_S_A   = 7;
    localparam int SIG_S_B   = 8;
    localparam int SIG_S_WEN = 9;

    string       exp_name [$];
    int          exp_sig  [$];
    logic [63:0] exp_val  [$];

    int checks   = 0;
    int failures = 0;

    event mon_ev;

    function automatic logic [63:0] actual(input int sig);
        case (sig)
            SIG_M_A:    return {32'h0, m_rdata_a};
            SIG_M_B:    return {32'h0, m_rdata_b};
            SIG_M_WEN:  return {32'h0, m_wen};
            SIG_NB_A:   return {32'h0, nb_rdata_a};
            SIG_NB_B:   return {32'h0, nb_rdata_b};
            SIG_Z0_A:   return {32'h0, z0_rdata_a};
            SIG_Z0_WEN: return {32'h0, z0_wen};
            SIG_S_A:    return {56'h0, s_rdata_a};
            SIG_S_B:    return {56'h0, s_rdata_b};
            SIG_S_WEN:  return {56'h0, s_wen};
            default:    return 64'hxxxx_xxxx_xxxx_xxxx;
        endcase
    endfunction

    // Monitor: on each strobe, drain the scoreboard against live DUT outputs.
    initial begin
        string       n;
        int          sg;
        logic [63:0] ev, av;
        forever begin
            @(mon_ev);
            while (exp_val.size() > 0) begin
                n  = exp_name.pop_front();
                sg = exp_sig.pop_front();
                ev = exp_val.pop_front();
                av = actual(sg);
                checks++;
                if (av !== ev) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, av, ev, $time);
                end
            end
        end
    end

    task automatic expect_val(input string n, input int sig, input logic [63:0] v);
        exp_name.push_back(n);
        exp_sig.push_back(sig);
        exp_val.push_back(v);
    endtask

    // Let combinational outputs settle, then strobe the monitor.
    task automatic fire();
        #1;
        ->mon_ev;
        #1;
    endtask

    initial begin
        RST_N = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0; RADDR_A = '0; RADDR_B = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr_a = '0; s_raddr_b = '0;

        // Reset state
        expect_val("rst_m_a", SIG_M_A, 64'h0);
        expect_val("rst_m_b", SIG_M_B, 64'h0);
        expect_val("rst_m_wen", SIG_M_WEN, 64'h0);
        expect_val("rst_z0_a", SIG_Z0_A, 64'h0);
        fire();
        @(negedge CLK); RST_N = 1'b1;

        // Write/read x5
        @(negedge CLK);
        WE = 1'b1; WADDR = 5'd5; WDATA = 32'h1234_5678; RADDR_B = 5'd5;
        expect_val("wr5_wen", SIG_M_WEN, 64'h0000_0020);
        expect_val("wr5_byp_b", SIG_M_B, 64'h1234_5678);
        expect_val("wr5_nb_pre", SIG_NB_B, 64'h0);
        fire();
        @(negedge CLK); WE = 1'b0;
        expect_val("rd5_m_b", SIG_M_B, 64'h1234_5678);
        expect_val("rd5_nb_b", SIG_NB_B, 64'h1234_5678);
        expect_val("idle_wen", SIG_M_WEN, 64'h0);
        fire();

        // Zero register
        @(negedge CLK);
        WE = 1'b1; WADDR = 5'd0; WDATA = 32'hFFFF_FFFF; RADDR_A = 5'd0;
        expect_val("zr_wen", SIG_M_WEN, 64'h0);
        expect_val("zr_a_wr", SIG_M_A, 64'h0);
        expect_val("z0_wen", SIG_Z0_WEN, 64'h1);
        expect_val("z0_byp_a", SIG_Z0_A, 64'hFFFF_FFFF);
        fire();
        @(negedge CLK); WE = 1'b0;
        expect_val("zr_a_after", SIG_M_A, 64'h0);
        expect_val("z0_a_after", SIG_Z0_A, 64'hFFFF_FFFF);
        fire();

        // Bypass vs no bypass on x3
        @(negedge CLK); WE = 1'b1; WADDR = 5'd3; WDATA = 32'h11;
        @(negedge CLK); WDATA = 32'h22; RADDR_A = 5'd3;
        expect_val("byp_m_a", SIG_M_A, 64'h22);
        expect_val("byp_nb_a_old", SIG_NB_A, 64'h11);
        fire();
        @(negedge CLK); WE = 1'b0;
        expect_val("byp_m_a_after", SIG_M_A, 64'h22);
        expect_val("byp_nb_a_new", SIG_NB_A, 64'h22);
        fire();

        // Dual read
        @(negedge CLK); WE = 1'b1; WADDR = 5'd1; WDATA = 32'hA;
        @(negedge CLK); WADDR = 5'd2; WDATA = 32'hB;
        @(negedge CLK); WE = 1'b0; RADDR_A = 5'd1; RADDR_B = 5'd2;
        expect_val("dual_a", SIG_M_A, 64'hA);
        expect_val("dual_b", SIG_M_B, 64'hB);
        expect_val("dual_nb_a", SIG_NB_A, 64'hA);
        fire();
        @(negedge CLK); RADDR_A = 5'd2;
        expect_val("same_a", SIG_M_A, 64'hB);
        expect_val("same_b", SIG_M_B, 64'hB);
        fire();

        // Back-to-back writes to x6
        @(negedge CLK); WE = 1'b1; WADDR = 5'd6; WDATA = 32'h100;
        @(negedge CLK); WDATA = 32'h200;
        @(negedge CLK); WE = 1'b0; RADDR_A = 5'd6;
        expect_val("b2b_m", SIG_M_A, 64'h200);
        expect_val("b2b_nb", SIG_NB_A, 64'h200);
        fire();

        // Asynchronous reset mid-cycle
        @(negedge CLK); WE = 1'b1; WADDR = 5'd7; WDATA = 32'hDEAD_BEEF;
        @(negedge CLK); WE = 1'b0; RADDR_A = 5'd7; RADDR_B = 5'd5;
        expect_val("pre_rst_a", SIG_M_A, 64'hDEAD_BEEF);
        expect_val("pre_rst_b", SIG_M_B, 64'h1234_5678);
        fire();
        RST_N = 1'b0;
        expect_val("async_rst_a", SIG_M_A, 64'h0);
        expect_val("async_rst_b", SIG_M_B, 64'h0);
        expect_val("async_rst_nb", SIG_NB_A, 64'h0);
        fire();

        // Write during reset: forwarded but not stored
        @(negedge CLK); WE = 1'b1; WADDR = 5'd9; WDATA = 32'h55; RADDR_A = 5'd9;
        expect_val("rstwr_byp", SIG_M_A, 64'h55);
        expect_val("rstwr_nb", SIG_NB_A, 64'h0);
        expect_val("rstwr_wen", SIG_M_WEN, 64'h0000_0200);
        fire();
        @(negedge CLK); WE = 1'b0;
        expect_val("rstwr_lost", SIG_M_A, 64'h0);
        fire();

        // First edge after release writes
        @(negedge CLK); RST_N = 1'b1; WE = 1'b1; WDATA = 32'h66;
        @(negedge CLK); WE = 1'b0;
        expect_val("resume_m", SIG_M_A, 64'h66);
        expect_val("resume_nb", SIG_NB_A, 64'h66);
        fire();

        // Narrow instance sweep
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            s_we = 1'b1; s_waddr = 3'(i); s_wdata = 8'(i + 1);
        end
        @(negedge CLK); s_we = 1'b0;
        expect_val("s_idle_wen", SIG_S_WEN, 64'h0);
        fire();
        for (int i = 0; i < 8; i++) begin
            s_raddr_a = 3'(i);
            s_raddr_b = 3'(7 - i);
            expect_val($sformatf("sweep_a%0d", i), SIG_S_A, (i == 0) ? 64'h0 : 64'(i + 1));
            expect_val($sformatf("sweep_b%0d", 7 - i), SIG_S_B, (i == 7) ? 64'h0 : 64'(8 - i));
            fire();
        end

        #2;
        checks++;
        if (exp_val.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_val.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, address width; register count NREGS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N, input, 1, reset: asynchronous and active-low.
REQ-007 SHALL have port WE, input, 1, write enable for the write port.
REQ-008 SHALL have port WADDR, input, ADDR_WIDTH, write register index.
REQ-009 SHALL have port WDATA, input, DATA_WIDTH, write data.
REQ-010 SHALL have port RADDR_A, input, ADDR_WIDTH, read port A register index.
REQ-011 SHALL have port RDATA_A, output, DATA_WIDTH, read port A data.
REQ-012 SHALL have port RADDR_B, input, ADDR_WIDTH, read port B register index.
REQ-013 SHALL have port RDATA_B, output, DATA_WIDTH, read port B data.
REQ-014 SHALL have port WEN_VEC, output, NREGS, one-hot decoded write-enable vector (observability).

Function
REQ-015 SHALL hold NREGS registers of DATA_WIDTH bits.
REQ-016 SHALL decode WADDR into WEN_VEC combinationally: bit WADDR high iff WE=1; all zero when WE=0.
REQ-017 SHALL force WEN_VEC[0]=0 when ZERO_REG=1, regardless of WE/WADDR.
REQ-018 SHALL load WDATA into register k on the rising CLK edge where WEN_VEC[k]=1; all others hold.
REQ-019 SHALL provide combinational (zero-latency) reads: RDATA_x = register[RADDR_x] in the same cycle.
REQ-020 SHALL return 0 on a read port whose address is 0 when ZERO_REG=1, including during bypass.
REQ-021 SHALL, when BYPASS=1, WE=1, WADDR=RADDR_x and the address is not a hardwired-zero register, drive RDATA_x = WDATA in that cycle.
REQ-022 SHALL, when BYPASS=0, drive RDATA_x with the pre-edge register value; the new value appears the cycle after the write edge.
REQ-023 SHALL serve both read ports independently; identical addresses on A and B return identical data.
REQ-024 SHALL make back-to-back writes to the same register in consecutive cycles leave the last-written value.
REQ-025 SHALL treat ZERO_REG=0 register 0 as an ordinary writable register.
REQ-026 SHALL be fully parameter-generic: no hardcoded 32 or 5 in decode or read muxing; legal ADDR_WIDTH 1..6, DATA_WIDTH 1..64.

Reset
REQ-027 SHALL clear every register to 0 immediately on RST_N falling, without waiting for CLK.
REQ-028 SHALL ignore writes while RST_N=0; a write coinciding with reset assertion is lost.
REQ-029 SHALL drive RDATA_A/RDATA_B to 0 during reset unless BYPASS forwarding applies (WE=1, matching nonzero address).
REQ-030 SHALL resume normal writes on the first rising CLK edge after RST_N returns high.

Verification
REQ-031 SHALL cover reset: write 0xDEADBEEF to x7, assert RST_N low mid-cycle -> RDATA_A (RADDR_A=7) reads 0x0 before next CLK edge.
REQ-032 SHALL cover write/read: WE=1, WADDR=5, WDATA=0x12345678, edge; RADDR_B=5 -> RDATA_B=0x12345678; WEN_VEC=0x00000020 during write cycle.
REQ-033 SHALL cover zero register: ZERO_REG=1, WE=1, WADDR=0, WDATA=0xFFFFFFFF -> WEN_VEC=0, RDATA_A (RADDR_A=0)=0 in write cycle and after.
REQ-034 SHALL cover bypass: BYPASS=1, x3=0x11, WE=1, WADDR=3, WDATA=0x22, RADDR_A=3 -> RDATA_A=0x22 same cycle; with BYPASS=0 -> 0x11 then 0x22 next cycle.
REQ-035 SHALL cover dual read: x1=0xA, x2=0xB, RADDR_A=1, RADDR_B=2 -> 0xA/0xB; both at 2 -> 0xB/0xB.
REQ-036 SHALL cover parameter sweep: ADDR_WIDTH=3, DATA_WIDTH=8, write i+1 to each reg i -> each reads back i+1 (reg 0 reads 0 with ZERO_REG=1).
